scoreboard_stall_unit: RTL and testbench

- Producer-side hazard control for the 5-stage pipeline; it complements the forwarding logic, which handles the consumer side.
- Tracks, per architectural register, how many cycles remain until an in-flight result becomes forwardable.
- Stalls fetch/decode on RAW (load-use, multi-cycle ops) and WAW hazards, inserts execute bubbles, and flushes on taken branches.
- Sits between decode and the ID/EX pipeline register control.

---
 rtl/scoreboard_stall_unit.sv | 112 +++++++++++
 tb/tb_scoreboard_stall_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/scoreboard_stall_unit.sv
// Purpose: per-register latency scoreboard; stalls decode on RAW/WAW hazards, bubbles EX, flushes on taken branch.
// Latency: outputs are combinational from counter state and decode inputs; counters update on the rising clk edge.
// Backpressure: stallF/stallD hold fetch/decode while any relevant counter is nonzero; a taken branch overrides any stall.
// Optional build macro SCOREBOARD_STATS_EN adds saturating stall_cycles / waw_stalls counters.
module scoreboard_stall_unit #(
  parameter int NREG    = 32,
  parameter int LAT_W   = 3,
  parameter int MAX_LAT = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_validD,
  input  logic             regwriteD,
  input  logic [4:0]       rdD,
  input  logic [LAT_W-1:0] latD,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic             rs1_usedD,
  input  logic             rs2_usedD,
  input  logic             branch_takenE,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             flushE,
  output logic [NREG-1:0]  busy_vec
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [15:0]      waw_stalls
`endif
);

  localparam logic [LAT_W-1:0] MAX_LAT_C = LAT_W'(MAX_LAT);

  // Cycles remaining until each register's in-flight result is forwardable.
  logic [LAT_W-1:0] cnt [NREG];

  logic [LAT_W-1:0] lat_clamp;
  logic             raw_hit;
  logic             waw_hit;
  logic             hazard;
  logic             fire;

  // Hazard detection: a source still counting down is RAW; a destination that would
  // complete after this younger write is WAW. A taken branch suppresses both.
  always_comb begin
    lat_clamp = (latD > MAX_LAT_C) ? MAX_LAT_C : latD;
    raw_hit   = (rs1_usedD && (rs1D != 5'd0) && (cnt[rs1D] != '0)) ||
                (rs2_usedD && (rs2D != 5'd0) && (cnt[rs2D] != '0));
    waw_hit   = regwriteD && (rdD != 5'd0) && (cnt[rdD] > lat_clamp);
    hazard    = issue_validD && (raw_hit || waw_hit) && !branch_takenE;
    fire      = issue_validD && !hazard && !branch_takenE;
  end

  // Pipeline control outputs; everything reads as zero while reset is asserted.
  always_comb begin
    stallF   = rst && hazard;
    stallD   = rst && hazard;
    flushE   = rst && (hazard || branch_takenE);
    flushD   = rst && branch_takenE;
    busy_vec = '0;
    for (int r = 0; r < NREG; r++) begin
      busy_vec[r] = rst && (cnt[r] != '0);
    end
  end

  // Counter update: issue loads the clamped latency (winning over decrement), else count down to 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (r == 0) begin
          cnt[r] <= '0;
        end else if (fire && regwriteD && (rdD == 5'(r))) begin
          cnt[r] <= lat_clamp;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - LAT_W'(1);
        end
      end
    end
  end

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] waw_cnt_q;

  // Saturating statistics: total stall cycles, and stalls caused purely by WAW.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      waw_cnt_q   <= '0;
    end else begin
      if (hazard && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (hazard && waw_hit && !raw_hit && (waw_cnt_q != '1)) begin
        waw_cnt_q <= waw_cnt_q + 16'd1;
      end
    end
  end

  // Statistics outputs follow the same reset masking as the control outputs.
  always_comb begin
    stall_cycles = rst ? stall_cnt_q : 32'd0;
    waw_stalls   = rst ? waw_cnt_q : 16'd0;
  end
`endif

endmodule

// File: tb/tb_scoreboard_stall_unit.sv
// Directed bench for scoreboard_stall_unit: each step drives decode inputs, queues the
// expected control outputs, and compares them at the falling edge before the state update.
module tb_scoreboard_stall_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_validD = 1'b0;
  logic        regwriteD = 1'b0;
  logic [4:0]  rdD = '0;
  logic [2:0]  latD = '0;
  logic [4:0]  rs1D = '0;
  logic [4:0]  rs2D = '0;
  logic        rs1_usedD = 1'b0;
  logic        rs2_usedD = 1'b0;
  logic        branch_takenE = 1'b0;
  logic        stallF, stallD, flushD, flushE;
  logic [31:0] busy_vec;

  typedef struct {
    logic        stall;
    logic        fl_d;
    logic        fl_e;
    logic [31:0] busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  scoreboard_stall_unit dut (
    .clk(clk), .rst(rst), .issue_validD(issue_validD), .regwriteD(regwriteD),
    .rdD(rdD), .latD(latD), .rs1D(rs1D), .rs2D(rs2D), .rs1_usedD(rs1_usedD),
    .rs2_usedD(rs2_usedD), .branch_takenE(branch_takenE), .stallF(stallF),
    .stallD(stallD), .flushD(flushD), .flushE(flushE), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rbit(input int n);
    logic [31:0] one;
    one = 32'd1;
    return one << n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One decode cycle: drive, queue expectation, compare at negedge, then advance past the edge.
  task automatic step(input string tag,
                      input logic v, input logic rw, input logic [4:0] rd, input logic [2:0] lat,
                      input logic [4:0] s1, input logic u1, input logic [4:0] s2, input logic u2,
                      input logic br,
                      input logic e_stall, input logic e_fld, input logic e_fle, input logic [31:0] e_busy);
    exp_t e;
    issue_validD = v; regwriteD = rw; rdD = rd; latD = lat;
    rs1D = s1; rs1_usedD = u1; rs2D = s2; rs2_usedD = u2; branch_takenE = br;
    e.stall = e_stall; e.fl_d = e_fld; e.fl_e = e_fle; e.busy = e_busy;
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard queue empty", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".stallF"}, 32'(stallF), 32'(e.stall));
      chk({tag, ".stallD"}, 32'(stallD), 32'(e.stall));
      chk({tag, ".flushD"}, 32'(flushD), 32'(e.fl_d));
      chk({tag, ".flushE"}, 32'(flushE), 32'(e.fl_e));
      chk({tag, ".busy"},   busy_vec,    e.busy);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with a would-be hazard and a branch driven: every output must read 0.
    rst = 1'b0;
    step("rst0", 1, 1, 5'd5, 3'd1, 5'd5, 1, 5'd0, 0, 1, 0, 0, 0, 32'h0);
    step("rst1", 1, 0, 5'd0, 3'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 32'h0);
    rst = 1'b1;

    // Load-use: one stall, then issue with r5 clear.
    step("ld_iss", 1, 1, 5'd5, 3'd1, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 32'h0);
    step("ld_stl", 1, 1, 5'd6, 3'd0, 5'd5, 1, 5'd0, 0, 0, 1, 0, 1, rbit(5));
    step("ld_go",  1, 1, 5'd6, 3'd0, 5'd5, 1, 5'd0, 0, 0, 0, 0, 0, 32'h0);

    // Multi-cycle latency 3 on r7: three stalls via rs2, then issue.
    step("mc_iss", 1, 1, 5'd7, 3'd3, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++)
      step("mc_stl", 1, 1, 5'd8, 3'd0, 5'd0, 0, 5'd7, 1, 0, 1, 0, 1, rbit(7));
    step("mc_go",  1, 1, 5'd8, 3'd0, 5'd0, 0, 5'd7, 1, 0, 0, 0, 0, 32'h0);

    // WAW on r9: older lat 4, one idle cycle, then younger lat 0 stalls at counts 3,2,1.
    step("waw_iss", 1, 1, 5'd9, 3'd4, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 32'h0);
    step("waw_idl", 0, 0, 5'd0, 3'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, rbit(9));
    for (int i = 0; i < 3; i++)
      step("waw_stl", 1, 1, 5'd9, 3'd0, 5'd1, 1, 5'd2, 1, 0, 1, 0, 1, rbit(9));
    step("waw_go",  1, 1, 5'd9, 3'd0, 5'd1, 1, 5'd2, 1, 0, 0, 0, 0, 32'h0);

    // Younger write finishing no earlier than the older one is not a WAW.
    step("nowaw_a", 1, 1, 5'd10, 3'd2, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 32'h0);
    step("nowaw_b", 1, 1, 5'd10, 3'd3, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, rbit(10));
    step("nowaw_c", 0, 0, 5'd0, 3'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, rbit(10));

    // latD=7 clamps to 6: six stalls on r11 (r10 still draining in the first one).
    step("clmp_iss", 1, 1, 5'd11, 3'd7, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, rbit(10));
    for (int i = 0; i < 6; i++)
      step("clmp_stl", 1, 0, 5'd0, 3'd0, 5'd11, 1, 5'd0, 0, 0, 1, 0, 1,
           (i == 0) ? (rbit(10) | rbit(11)) : rbit(11));
    step("clmp_go",  1, 0, 5'd0, 3'd0, 5'd11, 1, 5'd0, 0, 0, 0, 0, 0, 32'h0);

    // Branch beats a pending RAW; the wrong-path write to r13 must not be recorded.
    step("br_iss", 1, 1, 5'd12, 3'd2, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 32'h0);
    step("br_hit", 1, 1, 5'd13, 3'd3, 5'd12, 1, 5'd0, 0, 1, 0, 1, 1, rbit(12));
    step("br_aft", 0, 0, 5'd0, 3'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, rbit(12));

    // r0 destination is never tracked.
    step("r0_iss", 1, 1, 5'd0, 3'd5, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 32'h0);
    step("r0_chk", 0, 0, 5'd0, 3'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 32'h0);

    // Pending r3 named as unused sources causes no stall.
    step("unu_iss", 1, 1, 5'd3, 3'd2, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 32'h0);
    step("unu_chk", 1, 0, 5'd0, 3'd0, 5'd3, 0, 5'd3, 0, 0, 0, 0, 0, rbit(3));
    step("unu_end", 0, 0, 5'd0, 3'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, rbit(3));

    // Reset mid-stall: outputs zero during reset, dependent issues right after release.
    step("rms_iss", 1, 1, 5'd4, 3'd3, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 32'h0);
    step("rms_stl", 1, 0, 5'd0, 3'd0, 5'd4, 1, 5'd0, 0, 0, 1, 0, 1, rbit(4));
    rst = 1'b0;
    step("rms_rst", 1, 0, 5'd0, 3'd0, 5'd4, 1, 5'd0, 0, 0, 0, 0, 0, 32'h0);
    rst = 1'b1;
    step("rms_go",  1, 0, 5'd0, 3'd0, 5'd4, 1, 5'd0, 0, 0, 0, 0, 0, 32'h0);

    // Source equals destination: RAW stall until r5 drains, then issue re-arms r5.
    step("sd_iss", 1, 1, 5'd5, 3'd2, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 32'h0);
    step("sd_stl", 1, 1, 5'd5, 3'd2, 5'd5, 1, 5'd1, 1, 0, 1, 0, 1, rbit(5));
    step("sd_stl", 1, 1, 5'd5, 3'd2, 5'd5, 1, 5'd1, 1, 0, 1, 0, 1, rbit(5));
    step("sd_go",  1, 1, 5'd5, 3'd2, 5'd5, 1, 5'd1, 1, 0, 0, 0, 0, 32'h0);
    step("sd_arm", 0, 0, 5'd0, 3'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, rbit(5));

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL queue_drain leftover=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
